mem_port_arbiter: RTL and testbench

- Arbitrates one single-port, variable-latency unified memory between the instruction-fetch (IF) stage and the data-memory (MEM) stage of the 5-stage pipeline.
- Sequences each access with a req/ack handshake to the memory and returns a one-cycle ready pulse to the winning requester.
- Drives the stall signals consumed by the PC and pipeline registers.
- Data accesses have priority. A starvation limit guarantees IF progress, and a timeout guarantees that a hung memory cannot lock up the pipeline.

---
 rtl/mem_port_arbiter.sv | 124 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-port, variable-latency memory between instruction fetch and
// the data stage: data priority, IF starvation guard, and a per-access timeout.
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              stall_if,
    output logic              stall_mem,
    output logic              timeout_err
);
    typedef enum logic [1:0] {IDLE, GNT_IF, GNT_D, DONE} state_e;

    localparam int              SW         = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0]   STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic [9:0]      TO_LAST    = 10'(TIMEOUT - 1);

    state_e            state_q;
    logic              mem_req_q, mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q, if_rdata_q, d_rdata_q;
    logic              if_ready_q, d_ready_q, timeout_q;
    logic [SW-1:0]     starve_q, starve_d;
    logic [9:0]        tcnt_q;
    logic              pick_if;

    // NOTE: every always_comb output gets a value before any branch so no latch is inferred.
    always_comb begin
        pick_if  = if_req && (!d_req || starve_q == STARVE_MAX);
        starve_d = '0;
        if (!pick_if && if_req)
            starve_d = (starve_q == STARVE_MAX) ? STARVE_MAX : starve_q + SW'(1);
    end

    // NOTE: sequential state uses non-blocking assignments only; ready pulses default low each cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            if_ready_q  <= 1'b0;
            d_ready_q   <= 1'b0;
            timeout_q   <= 1'b0;
            starve_q    <= '0;
            tcnt_q      <= '0;
        end else begin
            if_ready_q <= 1'b0;
            d_ready_q  <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (if_req || d_req) begin
                        state_q     <= pick_if ? GNT_IF : GNT_D;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= pick_if ? 1'b0 : d_we;
                        mem_addr_q  <= pick_if ? if_addr : d_addr;
                        mem_wdata_q <= pick_if ? '0 : d_wdata;
                        starve_q    <= starve_d;
                        tcnt_q      <= '0;
                    end
                end
                GNT_IF, GNT_D: begin
                    // An ack in the final allowed cycle completes normally rather than aborting.
                    if (mem_ack || tcnt_q == TO_LAST) begin
                        state_q   <= DONE;
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        if (!mem_ack)
                            timeout_q <= 1'b1;
                        if (state_q == GNT_IF) begin
                            if_ready_q <= 1'b1;
                            if_rdata_q <= mem_ack ? mem_rdata : '0;
                        end else begin
                            d_ready_q <= 1'b1;
                            if (!mem_ack)
                                d_rdata_q <= '0;
                            else if (!mem_we_q)
                                d_rdata_q <= mem_rdata;
                        end
                    end else begin
                        tcnt_q <= tcnt_q + 10'd1;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_req     = mem_req_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign if_rdata    = if_rdata_q;
    assign d_rdata     = d_rdata_q;
    assign if_ready    = if_ready_q;
    assign d_ready     = d_ready_q;
    assign timeout_err = timeout_q;
    assign stall_if    = if_req & ~if_ready_q;
    assign stall_mem   = d_req & ~d_ready_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: an access-level timing model (arbitration edge plus
// access length) predicts every output each cycle, and literal expectations pin key cases.
module tb_mem_port_arbiter;
    localparam int SL = 4;
    localparam int TO = 8;

    logic        clk, reset;
    logic        if_req, d_req, d_we;
    logic [31:0] if_addr, d_addr, d_wdata;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        if_ready, d_ready, mem_req, mem_we, mem_ack;
    logic        stall_if, stall_mem, timeout_err;
    logic        rsp_ack, man_ack;
    logic [31:0] rsp_rdata, man_rdata;

    assign mem_ack   = rsp_ack | man_ack;
    assign mem_rdata = man_ack ? man_rdata : rsp_rdata;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(SL), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .stall_if(stall_if), .stall_mem(stall_mem), .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Memory behaviour per access, in arbitration order: ack in grant cycle 'delay' (0 = never).
    typedef struct {
        int          delay;
        logic [31:0] data;
    } acc_t;
    acc_t sched[$];

    task automatic sched_add(input int dly, input logic [31:0] val);
        acc_t e;
        e.delay = dly;
        e.data  = val;
        sched.push_back(e);
    endtask

    // Access model: arbitration at edge a_edge, access lasts len grant cycles, ready at a_edge+len.
    int          cyc, a_edge, len, next_free, starve, ack_j;
    bit          win_d, tmo, terr_m, in_grant, rdy;
    logic        w_we;
    logic [31:0] w_addr, w_wdata, data_m, exp_if_rdata, exp_d_rdata;
    acc_t        cur;

    task automatic model_clear();
        a_edge       = -1000;
        len          = 0;
        next_free    = 0;
        starve       = 0;
        tmo          = 1'b0;
        terr_m       = 1'b0;
        exp_if_rdata = '0;
        exp_d_rdata  = '0;
    endtask

    initial begin
        cyc       = 0;
        rsp_ack   = 1'b0;
        rsp_rdata = '0;
        model_clear();
        forever begin
            @(posedge clk);
            cyc++;
            if (reset) begin
                model_clear();
                rsp_ack = 1'b0;
                continue;
            end
            if (cyc >= next_free && (if_req || d_req)) begin
                win_d = !(if_req && (!d_req || starve == SL));
                if (!win_d)     starve = 0;
                else if (if_req) starve = (starve < SL) ? starve + 1 : SL;
                else            starve = 0;
                if (sched.size() > 0) cur = sched.pop_front();
                else begin cur.delay = 1; cur.data = '0; end
                ack_j     = cur.delay;
                data_m    = cur.data;
                tmo       = (ack_j == 0) || (ack_j > TO);
                len       = tmo ? TO : ack_j;
                a_edge    = cyc;
                next_free = cyc + len + 2;
                w_we      = win_d ? d_we : 1'b0;
                w_addr    = win_d ? d_addr : if_addr;
                w_wdata   = d_wdata;
            end
            rdy = (cyc == a_edge + len);
            if (rdy) begin
                if (tmo) begin
                    terr_m = 1'b1;
                    if (win_d) exp_d_rdata = '0; else exp_if_rdata = '0;
                end else if (!win_d) exp_if_rdata = data_m;
                else if (!w_we)      exp_d_rdata  = data_m;
            end
            in_grant = (cyc >= a_edge) && (cyc < a_edge + len);
            #1;
            check("mem_req", mem_req, in_grant);
            check("mem_we", mem_we, in_grant && w_we);
            if (in_grant) check("mem_addr", mem_addr, w_addr);
            if (in_grant && w_we) check("mem_wdata", mem_wdata, w_wdata);
            check("if_ready", if_ready, rdy && !win_d);
            check("d_ready", d_ready, rdy && win_d);
            check("if_rdata", if_rdata, exp_if_rdata);
            check("d_rdata", d_rdata, exp_d_rdata);
            check("timeout_err", timeout_err, terr_m);
            check("stall_if", stall_if, if_req && !(rdy && !win_d));
            check("stall_mem", stall_mem, d_req && !(rdy && win_d));
            if (in_grant && ack_j != 0 && (cyc - a_edge + 1) == ack_j) begin
                rsp_ack   = 1'b1;
                rsp_rdata = data_m;
            end else begin
                rsp_ack   = 1'b0;
                rsp_rdata = 32'hBAD0_0000 ^ 32'(cyc);
            end
        end
    end

    task automatic wait_ready(input bit want_d, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(want_d ? d_ready : if_ready) && n < 40);
        check(want_d ? "d_ready_seen" : "if_ready_seen", want_d ? d_ready : if_ready, 1'b1);
    endtask

    int n, g, d_done, if_at;

    initial begin
        reset = 1'b1; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        if_addr = '0; d_addr = '0; d_wdata = '0; man_ack = 1'b0; man_rdata = '0;
        repeat (3) @(negedge clk);
        check("rst_mem_req", mem_req, 1'b0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_ready", {if_ready, d_ready, timeout_err}, 3'b000);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // 1: IF-only fetch, ack in the third grant cycle
        sched_add(3, 32'h2002_0005);
        if_addr = 32'h0000_1004; if_req = 1'b1;
        @(negedge clk);
        check("t1_mem_addr", mem_addr, 32'h0000_1004);
        check("t1_mem_we", mem_we, 1'b0);
        check("t1_stall_if", stall_if, 1'b1);
        wait_ready(1'b0, n);
        check("t1_latency", n + 1, 4);
        check("t1_if_rdata", if_rdata, 32'h2002_0005);
        if_req = 1'b0;
        repeat (2) @(negedge clk);

        // 2: contested, data store wins, IF follows
        sched_add(1, 32'h0);
        sched_add(2, 32'h3003_0007);
        if_addr = 32'h0000_2000; d_addr = 32'h10; d_wdata = 32'hDEAD_BEEF; d_we = 1'b1;
        if_req = 1'b1; d_req = 1'b1;
        @(negedge clk);
        check("t2_mem_we", mem_we, 1'b1);
        check("t2_mem_addr", mem_addr, 32'h10);
        check("t2_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        wait_ready(1'b1, n);
        check("t2_if_not_yet", if_ready, 1'b0);
        check("t2_store_keeps_rdata", d_rdata, 32'h0);
        d_req = 1'b0; d_we = 1'b0;
        wait_ready(1'b0, n);
        check("t2_if_rdata", if_rdata, 32'h3003_0007);
        if_req = 1'b0;
        repeat (2) @(negedge clk);

        // 3: continuous data loads with IF pending; IF must win the fifth arbitration
        for (int i = 0; i < 4; i++) sched_add(1, 32'h4000_0000 + 32'(i));
        sched_add(1, 32'h5005_0005);
        for (int i = 4; i < 6; i++) sched_add(1, 32'h4000_0000 + 32'(i));
        d_we = 1'b0; d_addr = 32'h100; if_addr = 32'h3000;
        d_req = 1'b1; if_req = 1'b1;
        d_done = 0; if_at = -1; n = 0;
        while ((d_req || if_req) && n < 200) begin
            @(negedge clk);
            n++;
            if (d_ready) begin
                d_done++;
                if (d_done == 6) d_req = 1'b0;
                else d_addr = 32'h100 + 32'(4 * d_done);
            end
            if (if_ready) begin
                if_at  = d_done;
                if_req = 1'b0;
            end
        end
        check("t3_data_before_if", if_at, 4);
        check("t3_data_total", d_done, 6);
        check("t3_if_rdata", if_rdata, 32'h5005_0005);
        check("t3_last_d_rdata", d_rdata, 32'h4000_0005);
        repeat (2) @(negedge clk);

        // 4: memory never acks, access aborted after TO grant cycles
        sched_add(0, 32'hFFFF_FFFF);
        d_addr = 32'h200; d_req = 1'b1;
        g = 0; n = 0;
        do begin
            @(negedge clk);
            n++;
            if (mem_req) g++;
        end while (!d_ready && n < 40);
        check("t4_grant_cycles", g, TO);
        check("t4_d_ready", d_ready, 1'b1);
        check("t4_d_rdata", d_rdata, 32'h0);
        check("t4_timeout_err", timeout_err, 1'b1);
        d_req = 1'b0;
        repeat (5) @(negedge clk);
        check("t4_sticky", timeout_err, 1'b1);

        // 5: asynchronous reset mid-grant, stray ack afterwards
        sched_add(0, 32'h0);
        if_addr = 32'h5000; if_req = 1'b1;
        repeat (3) @(negedge clk);
        check("t5_in_grant", mem_req, 1'b1);
        #1 reset = 1'b1; if_req = 1'b0;
        #1;
        check("t5_mem_req_drop", mem_req, 1'b0);
        check("t5_err_clear", timeout_err, 1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        man_ack = 1'b1; man_rdata = 32'h7777_7777;
        @(negedge clk);
        man_ack = 1'b0;
        check("t5_no_ready", {if_ready, d_ready, mem_req}, 3'b000);
        check("t5_if_rdata", if_rdata, 32'h0);
        sched_add(1, 32'h8008_0008);
        d_addr = 32'h280; d_req = 1'b1;
        @(negedge clk);
        check("t5_idle_grant", mem_req, 1'b1);
        wait_ready(1'b1, n);
        check("t5_d_rdata", d_rdata, 32'h8008_0008);
        d_req = 1'b0;
        repeat (2) @(negedge clk);

        // 6: ack in the same cycle the timeout would fire
        sched_add(TO, 32'h6006_0006);
        d_addr = 32'h300; d_req = 1'b1;
        wait_ready(1'b1, n);
        check("t6_latency", n, TO + 1);
        check("t6_d_rdata", d_rdata, 32'h6006_0006);
        check("t6_timeout_err", timeout_err, 1'b0);
        d_req = 1'b0;
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
